// File: rtl/prio_encoder_rr.sv
// prio_encoder_rr: priority encoder with selectable fixed / round-robin arbitration and a
// single registered output stage under valid/ready handshaking (1-cycle latency).
//
// Ports:
//   i_clk          clock, all state on rising edge
//   i_rst          synchronous active-high reset
//   i_req[N-1:0]   request vector, bit k = request k
//   i_rr_en        0 = fixed priority (bit N-1 highest), 1 = round-robin
//   i_in_valid     i_req/i_rr_en valid this cycle
//   o_in_ready     block can accept a request this cycle
//   o_out_valid    result registers hold an unconsumed result
//   i_out_ready    consumer takes the result this cycle
//   o_out_idx      granted index (0 when no request)
//   o_out_onehot   one-hot of granted index, all-zero when no request
//   o_out_none     accepted request vector was all-zero
module prio_encoder_rr #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 3
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [N-1:0] i_req,
  input  logic         i_rr_en,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [W-1:0] o_out_idx,
  output logic [N-1:0] o_out_onehot,
  output logic         o_out_none
);

  if (N < 2 || W != $clog2(N)) begin : g_bad_param
    $error("prio_encoder_rr: N must be >= 2 and W must equal clog2(N)");
  end

  logic         r_valid;
  logic [W-1:0] r_idx;
  logic [N-1:0] r_onehot;
  logic         r_none;
  logic [W-1:0] r_ptr;

  logic         w_accept;
  logic [W-1:0] w_start;
  logic [W-1:0] w_pos;
  logic         w_found;
  logic [W-1:0] w_grant;
  logic [N-1:0] w_onehot;
  logic [W-1:0] w_ptr_next;

  assign o_in_ready = !r_valid || i_out_ready;
  assign w_accept   = i_in_valid && o_in_ready;

  // Fixed priority is round-robin with the search starting at N-1, which also makes the
  // reset pointer (N-1) grant identically to fixed mode.
  assign w_start = i_rr_en ? r_ptr : W'(N - 1);

  // Descending search from w_start, wrapping modulo N; first set request wins.
  always_comb begin
    int s;
    int p;
    w_found = 1'b0;
    w_grant = '0;
    w_pos   = '0;
    s       = int'(w_start);
    for (int i = 0; i < int'(N); i++) begin
      p     = (s >= i) ? (s - i) : (s + int'(N) - i);
      w_pos = W'(p);
      if (!w_found && i_req[w_pos]) begin
        w_found = 1'b1;
        w_grant = w_pos;
      end
    end
  end

  always_comb begin
    w_onehot = '0;
    for (int k = 0; k < int'(N); k++) begin
      w_onehot[k] = w_found && (w_grant == W'(k));
    end
  end

  // Pointer moves just below the winner so the winner becomes lowest priority next time.
  assign w_ptr_next = (w_grant == '0) ? W'(N - 1) : (w_grant - W'(1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid  <= 1'b0;
      r_idx    <= '0;
      r_onehot <= '0;
      r_none   <= 1'b0;
      r_ptr    <= W'(N - 1);
    end else if (w_accept) begin
      r_valid  <= 1'b1;
      r_idx    <= w_grant;
      r_onehot <= w_onehot;
      r_none   <= !w_found;
      if (i_rr_en && w_found) begin
        r_ptr <= w_ptr_next;
      end
    end else if (i_out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_out_valid  = r_valid;
  assign o_out_idx    = r_idx;
  assign o_out_onehot = r_onehot;
  assign o_out_none   = r_none;

endmodule
